cond_logic: RTL and testbench

COND_LOGIC -- requirements
Module: cond_logic

---
 rtl/cond_logic_pkg.sv | 23 ++
 rtl/flopenr.sv | 15 +
 rtl/cond_logic.sv | 81 ++++++++
 tb/tb_cond_logic.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/cond_logic_pkg.sv
// cond_logic_pkg: condition-code encodings and flag bit positions
package cond_logic_pkg;
    localparam logic [3:0] EQ = 4'b0000;
    localparam logic [3:0] NE = 4'b0001;
    localparam logic [3:0] CS = 4'b0010;
    localparam logic [3:0] CC = 4'b0011;
    localparam logic [3:0] MI = 4'b0100;
    localparam logic [3:0] PL = 4'b0101;
    localparam logic [3:0] VS = 4'b0110;
    localparam logic [3:0] VC = 4'b0111;
    localparam logic [3:0] HI = 4'b1000;
    localparam logic [3:0] LS = 4'b1001;
    localparam logic [3:0] GE = 4'b1010;
    localparam logic [3:0] LT = 4'b1011;
    localparam logic [3:0] GT = 4'b1100;
    localparam logic [3:0] LE = 4'b1101;
    localparam logic [3:0] AL = 4'b1110;
    localparam logic [3:0] NV = 4'b1111;
    localparam int N_BIT = 3;
    localparam int Z_BIT = 2;
    localparam int C_BIT = 1;
    localparam int V_BIT = 0;
endpackage

// File: rtl/flopenr.sv
// flopenr: enable-gated register with asynchronous active-low clear
module flopenr #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    // load d when enabled, clear at once when reset_n falls
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) q <= '0;
        else if (en) q <= d;
endmodule

// File: rtl/cond_logic.sv
// cond_logic: condition evaluation, flag register and write-enable gating
module cond_logic
    import cond_logic_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic [3:0]  Cond,
    input  logic [3:0]  ALUFlags,
    input  logic [1:0]  FlagW,
    input  logic        CondLatch,
    input  logic        PCS,
    input  logic        RegW,
    input  logic        MemW,
    input  logic        NextPC,
    output logic        PCWrite,
    output logic        RegWrite,
    output logic        MemWrite,
    output logic [3:0]  Flags,
    output logic        CondExOut,
    output logic [15:0] SkipCount,
    output logic        UndefCond
);
    logic cond_ex, n, z, c, v;

    assign n = Flags[N_BIT];
    assign z = Flags[Z_BIT];
    assign c = Flags[C_BIT];
    assign v = Flags[V_BIT];

    // decode the condition field against the architectural flags; NV never executes
    always_comb begin
        cond_ex = 1'b0;
        case (Cond)
            EQ: cond_ex = z;
            NE: cond_ex = ~z;
            CS: cond_ex = c;
            CC: cond_ex = ~c;
            MI: cond_ex = n;
            PL: cond_ex = ~n;
            VS: cond_ex = v;
            VC: cond_ex = ~v;
            HI: cond_ex = c & ~z;
            LS: cond_ex = ~c | z;
            GE: cond_ex = n ~^ v;
            LT: cond_ex = n ^ v;
            GT: cond_ex = ~z & (n ~^ v);
            LE: cond_ex = z | (n ^ v);
            AL: cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    end

    flopenr #(.WIDTH(2)) nz_reg (
        .clk(clk), .reset_n(reset_n), .en(FlagW[1] & CondExOut),
        .d(ALUFlags[3:2]), .q(Flags[3:2])
    );

    flopenr #(.WIDTH(2)) cv_reg (
        .clk(clk), .reset_n(reset_n), .en(FlagW[0] & CondExOut),
        .d(ALUFlags[1:0]), .q(Flags[1:0])
    );

    flopenr #(.WIDTH(1)) cond_reg (
        .clk(clk), .reset_n(reset_n), .en(CondLatch),
        .d(cond_ex), .q(CondExOut)
    );

    assign PCWrite  = (PCS & CondExOut) | NextPC;
    assign RegWrite = RegW & CondExOut;
    assign MemWrite = MemW & CondExOut;

    // count squashed instructions, saturating instead of wrapping
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) SkipCount <= '0;
        else if (CondLatch && !cond_ex && SkipCount != 16'hFFFF) SkipCount <= SkipCount + 16'd1;

    // remember that an NV condition was ever decoded
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) UndefCond <= 1'b0;
        else if (CondLatch && Cond == NV) UndefCond <= 1'b1;
endmodule

// File: tb/tb_cond_logic.sv
// tb_cond_logic: table-driven and directed checks for cond_logic
module tb_cond_logic;
    logic        clk = 1'b0;
    logic        reset_n;
    logic [3:0]  Cond, ALUFlags;
    logic [1:0]  FlagW;
    logic        CondLatch, PCS, RegW, MemW, NextPC;
    logic        PCWrite, RegWrite, MemWrite, CondExOut, UndefCond;
    logic [3:0]  Flags;
    logic [15:0] SkipCount;

    int checks = 0;
    int errors = 0;

    cond_logic dut (
        .clk(clk), .reset_n(reset_n), .Cond(Cond), .ALUFlags(ALUFlags),
        .FlagW(FlagW), .CondLatch(CondLatch), .PCS(PCS), .RegW(RegW),
        .MemW(MemW), .NextPC(NextPC), .PCWrite(PCWrite), .RegWrite(RegWrite),
        .MemWrite(MemWrite), .Flags(Flags), .CondExOut(CondExOut),
        .SkipCount(SkipCount), .UndefCond(UndefCond)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] flags;
        logic [3:0] cond;
        logic       ex;
    } vec_t;

    vec_t vecs [20];

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic latch(input logic [3:0] c);
        Cond = c;
        CondLatch = 1'b1;
        tick();
        CondLatch = 1'b0;
    endtask

    task automatic set_flags(input logic [3:0] f);
        latch(4'b1110);
        FlagW = 2'b11;
        ALUFlags = f;
        tick();
        FlagW = 2'b00;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        vecs[0]  = '{4'b0100, 4'b0000, 1'b1};
        vecs[1]  = '{4'b0000, 4'b0000, 1'b0};
        vecs[2]  = '{4'b0000, 4'b0001, 1'b1};
        vecs[3]  = '{4'b0100, 4'b0001, 1'b0};
        vecs[4]  = '{4'b0010, 4'b0010, 1'b1};
        vecs[5]  = '{4'b0010, 4'b0011, 1'b0};
        vecs[6]  = '{4'b1000, 4'b0100, 1'b1};
        vecs[7]  = '{4'b1000, 4'b0101, 1'b0};
        vecs[8]  = '{4'b0001, 4'b0110, 1'b1};
        vecs[9]  = '{4'b0000, 4'b0111, 1'b1};
        vecs[10] = '{4'b0010, 4'b1000, 1'b1};
        vecs[11] = '{4'b0110, 4'b1000, 1'b0};
        vecs[12] = '{4'b0110, 4'b1001, 1'b1};
        vecs[13] = '{4'b1001, 4'b1010, 1'b1};
        vecs[14] = '{4'b1000, 4'b1011, 1'b1};
        vecs[15] = '{4'b0000, 4'b1100, 1'b1};
        vecs[16] = '{4'b0100, 4'b1100, 1'b0};
        vecs[17] = '{4'b1000, 4'b1101, 1'b1};
        vecs[18] = '{4'b0000, 4'b1110, 1'b1};
        vecs[19] = '{4'b1111, 4'b1111, 1'b0};

        reset_n = 1'b0;
        Cond = 4'b0000; ALUFlags = 4'b0000; FlagW = 2'b00;
        CondLatch = 1'b0; PCS = 1'b0; RegW = 1'b0; MemW = 1'b0; NextPC = 1'b0;
        #3;
        chk("rst_flags", {12'h0, Flags}, 16'h0);
        chk("rst_condex", {15'h0, CondExOut}, 16'h0);
        chk("rst_skip", SkipCount, 16'h0);
        chk("rst_undef", {15'h0, UndefCond}, 16'h0);
        @(negedge clk);
        reset_n = 1'b1;

        // decode table: load flags, latch the condition, observe gated writes
        for (int i = 0; i < 20; i++) begin
            set_flags(vecs[i].flags);
            chk($sformatf("flags_v%0d", i), {12'h0, Flags}, {12'h0, vecs[i].flags});
            PCS = 1'b1; RegW = 1'b1; MemW = 1'b1; NextPC = 1'b0;
            latch(vecs[i].cond);
            chk($sformatf("condex_v%0d_c%h_f%h", i, vecs[i].cond, vecs[i].flags), {15'h0, CondExOut}, {15'h0, vecs[i].ex});
            chk($sformatf("regwrite_v%0d", i), {15'h0, RegWrite}, {15'h0, vecs[i].ex});
            chk($sformatf("memwrite_v%0d", i), {15'h0, MemWrite}, {15'h0, vecs[i].ex});
            chk($sformatf("pcwrite_v%0d", i), {15'h0, PCWrite}, {15'h0, vecs[i].ex});
            PCS = 1'b0; RegW = 1'b0; MemW = 1'b0;
        end
        chk("table_skip", SkipCount, 16'd7);
        chk("table_undef", {15'h0, UndefCond}, 16'h1);
        NextPC = 1'b1;
        #1;
        chk("fetch_pcwrite", {15'h0, PCWrite}, 16'h1);
        NextPC = 1'b0;

        // REQ-034 style: false EQ squashes memory and PC writes
        do_reset();
        MemW = 1'b1; PCS = 1'b1;
        latch(4'b0000);
        chk("squash_mem", {15'h0, MemWrite}, 16'h0);
        chk("squash_pc", {15'h0, PCWrite}, 16'h0);
        chk("squash_skip", SkipCount, 16'h1);
        MemW = 1'b0; PCS = 1'b0;

        // split flag halves
        latch(4'b1110);
        FlagW = 2'b10; ALUFlags = 4'b1111;
        tick();
        chk("nz_update", {12'h0, Flags}, 16'h000C);
        FlagW = 2'b01; ALUFlags = 4'b0011;
        tick();
        chk("cv_update", {12'h0, Flags}, 16'h000F);

        // no update when the latched condition failed
        FlagW = 2'b00;
        latch(4'b0001);
        chk("ne_false", {15'h0, CondExOut}, 16'h0);
        FlagW = 2'b11; ALUFlags = 4'b1010;
        tick();
        chk("flags_hold", {12'h0, Flags}, 16'h000F);
        FlagW = 2'b00;
        latch(4'b1111);
        chk("nv_condex", {15'h0, CondExOut}, 16'h0);
        repeat (10) tick();
        chk("nv_undef_sticky", {15'h0, UndefCond}, 16'h1);
        chk("nv_condex_hold", {15'h0, CondExOut}, 16'h0);

        // latch coincides with flag update: decision uses old flags
        do_reset();
        latch(4'b1110);
        Cond = 4'b0000; CondLatch = 1'b1; FlagW = 2'b11; ALUFlags = 4'b0100;
        tick();
        CondLatch = 1'b0; FlagW = 2'b00;
        chk("coincide_condex", {15'h0, CondExOut}, 16'h0);
        chk("coincide_flags", {12'h0, Flags}, 16'h0004);

        // saturation of the skip counter
        do_reset();
        Cond = 4'b0000; CondLatch = 1'b1;
        repeat (65534) @(posedge clk);
        #1;
        chk("skip_fffe", SkipCount, 16'hFFFE);
        repeat (3) @(posedge clk);
        #1;
        chk("skip_sat", SkipCount, 16'hFFFF);
        CondLatch = 1'b0;
        tick();
        chk("skip_hold", SkipCount, 16'hFFFF);

        // asynchronous reset between edges
        latch(4'b1110);
        FlagW = 2'b11; ALUFlags = 4'b1111;
        tick();
        FlagW = 2'b00;
        RegW = 1'b1; MemW = 1'b1; PCS = 1'b1; NextPC = 1'b1;
        #1;
        chk("pre_rst_regwrite", {15'h0, RegWrite}, 16'h1);
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_regwrite", {15'h0, RegWrite}, 16'h0);
        chk("arst_memwrite", {15'h0, MemWrite}, 16'h0);
        chk("arst_pcwrite", {15'h0, PCWrite}, 16'h1);
        chk("arst_flags", {12'h0, Flags}, 16'h0);
        chk("arst_condex", {15'h0, CondExOut}, 16'h0);
        chk("arst_skip", SkipCount, 16'h0);
        chk("arst_undef", {15'h0, UndefCond}, 16'h0);
        NextPC = 1'b0;
        #1;
        chk("arst_pcwrite_nopc", {15'h0, PCWrite}, 16'h0);
        reset_n = 1'b1;
        RegW = 1'b0; MemW = 1'b0; PCS = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
